// File: rtl/conversao_bin_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double-dabble, one bit per clock).
// start/busy/done handshake; operands above 10**DIGITS-1 saturate to all nines with ovf set.
module conversao_bin_bcd_seq #(
  parameter int WIDTH_IN = 14,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH_IN-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH_IN + 1);
  localparam logic [WIDTH_IN-1:0] MAXV = WIDTH_IN'(10**DIGITS - 1);
  localparam logic [CW-1:0]       LAST = CW'(WIDTH_IN - 1);
  localparam logic [BW-1:0]       SAT  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [WIDTH_IN-1:0]       bin_r;
  logic [BW-1:0]             scr_r;
  logic [CW-1:0]             cnt_r;
  logic                      ovfp_r;
  logic [BW-1:0]             adj_s;
  logic [BW+WIDTH_IN-1:0]    shl_s;

  // Add 3 to every nibble that is 5 or more; nibbles are independent, no carries.
  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign adj_s = add3_all(scr_r);
  assign shl_s = {adj_s, bin_r} << 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST) begin
          state_s = FINISH;
        end else begin
          state_s = SHIFT;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; bcd_out/ovf only move in FINISH
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r   <= '0;
      scr_r   <= '0;
      cnt_r   <= '0;
      ovfp_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r  <= bin_in;
            scr_r  <= '0;
            cnt_r  <= '0;
            ovfp_r <= (bin_in > MAXV);
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          scr_r <= shl_s[BW+WIDTH_IN-1:WIDTH_IN];
          bin_r <= shl_s[WIDTH_IN-1:0];
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FINISH: begin
          bcd_out <= ovfp_r ? SAT : scr_r;
          ovf     <= ovfp_r;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conversao_bin_bcd_seq.sv
// Scoreboard bench for conversao_bin_bcd_seq: driver pushes decimal-model results,
// a monitor pops and compares on every done pulse, including latency and busy length.
module tb_conversao_bin_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  typedef struct {
    logic [15:0] bcd;
    logic        o;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   bl    = 0;
  exp_t last_e;

  conversao_bin_bcd_seq #(.WIDTH_IN(14), .DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_model(input int v, input int acc);
    exp_t e;
    e.acc = acc;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.o   = 1'b1;
    end else begin
      e.bcd = 16'h0000;
      e.o   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        int d;
        d = (v / (10**i)) % 10;
        e.bcd[4*i +: 4] = 4'(d);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst) begin
      bl = 0;
    end else begin
      if (busy) begin
        bl++;
      end else if (bl != 0) begin
        chk("busy_len", bl, 15);
        bl = 0;
      end
      if (done) begin
        chk("done_busy_excl", int'(busy), 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got bcd=%h ovf=%0b, no result expected", bcd_out, ovf);
        end else begin
          e = q.pop_front();
          chk("bcd_out", int'(bcd_out), int'(e.bcd));
          chk("ovf", int'(ovf), int'(e.o));
          chk("latency", cyc, e.acc + 15);
          last_e = e;
        end
      end
    end
  end

  // Single start pulse, then wait until the next accept opportunity
  task automatic issue(input int v);
    start  = 1'b1;
    bin_in = 14'(v);
    q.push_back(ref_model(v, cyc + 1));
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom);
    repeat (15) @(negedge clk);
  endtask

  // Start held high; the next operand is presented exactly when the done cycle arrives
  task automatic b2b(input int v);
    start  = 1'b1;
    bin_in = 14'(v);
    q.push_back(ref_model(v, cyc + 1));
    @(negedge clk);
    bin_in = 14'($urandom);
    repeat (15) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_bcd"}, int'(bcd_out), 0);
  endtask

  initial begin
    int v;
    int t;
    int b2b_vals[7] = '{1, 9, 10, 99, 100, 999, 1000};
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 14'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    issue(0);
    issue(1234);
    issue(9999);
    issue(10000);
    issue(16383);

    // start during busy must be ignored
    start  = 1'b1;
    bin_in = 14'd567;
    q.push_back(ref_model(567, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // reset in the middle of a conversion
    start  = 1'b1;
    bin_in = 14'd8888;
    q.push_back(ref_model(8888, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk_zero("abort");
    issue(305);

    foreach (b2b_vals[i]) b2b(b2b_vals[i]);
    start = 1'b0;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 1500; n++) begin
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if ($urandom_range(0, 1) == 0) begin
        b2b(v);
      end else begin
        issue(v);
      end
    end
    start = 1'b0;

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    repeat (5) @(negedge clk);
    chk("hold_bcd", int'(bcd_out), int'(last_e.bcd));
    chk("hold_ovf", int'(ovf), int'(last_e.o));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
